// File: rtl/l1_cache_pkg.sv
// ============================================================================
// Module   : l1_cache_pkg
// Purpose  : Shared types and width helpers for the direct-mapped L1 cache.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package l1_cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_WRITE   = 2'd2,
    ST_RESPOND = 2'd3
  } state_e;

  localparam int c_default_data_width = 32;
  localparam int c_default_block_size = 32;

  function automatic int offset_width(input int block_size);
    return $clog2(block_size);
  endfunction

  function automatic int index_width(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_width(input int addr_width, input int block_size, input int num_lines);
    return addr_width - index_width(num_lines) - offset_width(block_size);
  endfunction

  typedef logic [c_default_block_size-1:0][c_default_data_width-1:0] block_t;

endpackage

`default_nettype wire

// File: rtl/l1_cache_if.sv
// ============================================================================
// Module   : l1_cache_if
// Purpose  : CPU load/store port and L2 block port of the L1 cache.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface l1_cache_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int BLOCK_SIZE = 32
);
  logic [ADDR_WIDTH-1:0]                  cpu_addr;
  logic [DATA_WIDTH-1:0]                  cpu_wdata;
  logic                                   cpu_rd;
  logic                                   cpu_wr;
  logic [DATA_WIDTH-1:0]                  cpu_rdata;
  logic                                   cpu_ready;
  logic                                   cpu_hit;
  logic                                   cpu_busy;
  logic [ADDR_WIDTH-1:0]                  l2_addr;
  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0]  l2_data_out;
  logic                                   l2_read;
  logic                                   l2_write;
  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0]  l2_block_data_in;
  logic                                   l2_block_valid;
  logic                                   l2_ready;

  // Cache side
  modport master (
    input  cpu_addr, cpu_wdata, cpu_rd, cpu_wr,
    input  l2_block_data_in, l2_block_valid, l2_ready,
    output cpu_rdata, cpu_ready, cpu_hit, cpu_busy,
    output l2_addr, l2_data_out, l2_read, l2_write
  );

  // CPU / L2 side
  modport slave (
    output cpu_addr, cpu_wdata, cpu_rd, cpu_wr,
    output l2_block_data_in, l2_block_valid, l2_ready,
    input  cpu_rdata, cpu_ready, cpu_hit, cpu_busy,
    input  l2_addr, l2_data_out, l2_read, l2_write
  );
endinterface

`default_nettype wire

// File: rtl/l1_cache_line_store.sv
// ============================================================================
// Module   : l1_line_store
// Purpose  : Tag/valid/data arrays; combinational lookup, registered fill and
//            word-merge writes, both at the current access index.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module l1_line_store #(
  parameter int DATA_WIDTH   = 32,
  parameter int BLOCK_SIZE   = 32,
  parameter int NUM_LINES    = 8,
  parameter int INDEX_WIDTH  = 3,
  parameter int OFFSET_WIDTH = 5,
  parameter int TAG_WIDTH    = 3
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [INDEX_WIDTH-1:0]                lk_index,
  input  logic [TAG_WIDTH-1:0]                  lk_tag,
  input  logic [OFFSET_WIDTH-1:0]               lk_offset,
  output logic                                  lk_hit,
  output logic [DATA_WIDTH-1:0]                 lk_word,
  output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] lk_block,
  input  logic                                  fill_en,
  input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] fill_block,
  input  logic                                  wr_en,
  input  logic [DATA_WIDTH-1:0]                 wr_data
);

  logic [NUM_LINES-1:0]                                 valid_q, valid_d;
  logic [NUM_LINES-1:0][TAG_WIDTH-1:0]                  tag_q, tag_d;
  logic [NUM_LINES-1:0][BLOCK_SIZE-1:0][DATA_WIDTH-1:0] data_q, data_d;

  assign lk_hit   = valid_q[lk_index] && (tag_q[lk_index] == lk_tag);
  assign lk_block = data_q[lk_index];
  assign lk_word  = data_q[lk_index][lk_offset];

  // A store miss fills and merges in the same cycle; the word write wins.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill_en) begin
      valid_d[lk_index] = 1'b1;
      tag_d[lk_index]   = lk_tag;
      data_d[lk_index]  = fill_block;
    end
    if (wr_en) begin
      data_d[lk_index][lk_offset] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

`default_nettype wire

// File: rtl/l1_cache.sv
// ============================================================================
// Module   : l1_cache
// Purpose  : Direct-mapped, write-through/write-allocate L1 data cache.
//            Optional hit/miss counters under L1_CACHE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module l1_cache
  import l1_cache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int BLOCK_SIZE = 32,
  parameter int NUM_LINES  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  l1_cache_if.master  bus
`ifdef L1_CACHE_STATS_EN
  ,
  output logic [15:0] stat_hits,
  output logic [15:0] stat_misses
`endif
);

  localparam int c_off_w = offset_width(BLOCK_SIZE);
  localparam int c_idx_w = index_width(NUM_LINES);
  localparam int c_tag_w = tag_width(ADDR_WIDTH, BLOCK_SIZE, NUM_LINES);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    is_wr_q, is_wr_d;
  logic                    hit_q, hit_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    ready_q, ready_d;
  logic                    chit_q, chit_d;
  logic                    busy_q, busy_d;

  logic                    accept_w;
  logic [ADDR_WIDTH-1:0]   lk_addr_w;
  logic                    lk_hit_w;
  logic [DATA_WIDTH-1:0]   lk_word_w;
  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] lk_block_w;
  logic                    fill_en_w;
  logic                    wr_en_w;
  logic [DATA_WIDTH-1:0]   wr_data_w;
  logic                    xfer_w;

  assign accept_w  = (state_q == ST_IDLE) && !busy_q && (bus.cpu_rd || bus.cpu_wr);
  assign lk_addr_w = ((state_q == ST_IDLE) && !busy_q) ? bus.cpu_addr : addr_q;

  l1_line_store #(
    .DATA_WIDTH   (DATA_WIDTH),
    .BLOCK_SIZE   (BLOCK_SIZE),
    .NUM_LINES    (NUM_LINES),
    .INDEX_WIDTH  (c_idx_w),
    .OFFSET_WIDTH (c_off_w),
    .TAG_WIDTH    (c_tag_w)
  ) u_store (
    .clk        (clk),
    .rst_n      (rst_n),
    .lk_index   (lk_addr_w[c_off_w +: c_idx_w]),
    .lk_tag     (lk_addr_w[ADDR_WIDTH-1 -: c_tag_w]),
    .lk_offset  (lk_addr_w[c_off_w-1:0]),
    .lk_hit     (lk_hit_w),
    .lk_word    (lk_word_w),
    .lk_block   (lk_block_w),
    .fill_en    (fill_en_w),
    .fill_block (bus.l2_block_data_in),
    .wr_en      (wr_en_w),
    .wr_data    (wr_data_w)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    is_wr_d   = is_wr_q;
    hit_d     = hit_q;
    rdata_d   = '0;
    ready_d   = 1'b0;
    chit_d    = 1'b0;
    busy_d    = ready_q ? 1'b0 : busy_q;
    fill_en_w = 1'b0;
    wr_en_w   = 1'b0;
    wr_data_w = wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept_w) begin
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
          is_wr_d = bus.cpu_wr;
          hit_d   = lk_hit_w;
          busy_d  = 1'b1;
          if (lk_hit_w && !bus.cpu_wr) begin
            ready_d = 1'b1;
            chit_d  = 1'b1;
            rdata_d = lk_word_w;
          end else if (lk_hit_w) begin
            wr_en_w   = 1'b1;
            wr_data_w = bus.cpu_wdata;
            state_d   = ST_WRITE;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        // A ready without valid data leaves us here, re-requesting next cycle.
        if (bus.l2_ready && bus.l2_block_valid) begin
          fill_en_w = 1'b1;
          wr_en_w   = is_wr_q;
          state_d   = is_wr_q ? ST_WRITE : ST_RESPOND;
        end
      end
      ST_WRITE: begin
        if (bus.l2_ready) begin
          state_d = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        ready_d = 1'b1;
        chit_d  = hit_q;
        rdata_d = is_wr_q ? '0 : lk_word_w;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      hit_q   <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      chit_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
      hit_q   <= hit_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      chit_q  <= chit_d;
      busy_q  <= busy_d;
    end
  end

  // Requests drop combinationally with l2_ready so L2 never sees a stale one.
  assign xfer_w           = (state_q == ST_FETCH) || (state_q == ST_WRITE);
  assign bus.l2_read      = (state_q == ST_FETCH) && !bus.l2_ready;
  assign bus.l2_write     = (state_q == ST_WRITE) && !bus.l2_ready;
  assign bus.l2_addr      = xfer_w ? {addr_q[ADDR_WIDTH-1:c_off_w], {c_off_w{1'b0}}} : '0;
  assign bus.l2_data_out  = (state_q == ST_WRITE) ? lk_block_w : '0;
  assign bus.cpu_rdata    = rdata_q;
  assign bus.cpu_ready    = ready_q;
  assign bus.cpu_hit      = chit_q;
  assign bus.cpu_busy     = busy_q;

`ifdef L1_CACHE_STATS_EN
  logic [15:0] hits_q, hits_d, misses_q, misses_d;

  always_comb begin
    hits_d   = hits_q;
    misses_d = misses_q;
    if (ready_d) begin
      if (chit_d) begin
        if (hits_q != 16'hFFFF) hits_d = hits_q + 16'd1;
      end else begin
        if (misses_q != 16'hFFFF) misses_d = misses_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_l1_cache.sv
// ============================================================================
// Module   : tb_l1_cache
// Purpose  : Self-checking bench for l1_cache with a behavioural L2 and a
//            response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_l1_cache;

  typedef logic [31:0][31:0] blk_t;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_hit;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    bit          hit;
  } exp_t;

  localparam int c_l2_lat = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  l1_cache_if #(.DATA_WIDTH(32), .ADDR_WIDTH(11), .BLOCK_SIZE(32)) bus ();

  l1_cache dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          ready_cyc = 0;
  int          req_cyc = 0;
  int          l2_rd_cycles = 0;
  int          wr_cnt = 0;
  logic [10:0] l2_rd_addr = '0;
  logic [10:0] last_wr_addr = '0;
  blk_t        last_wr_blk;
  bit          l2_stall = 1'b0;
  bit          nack_next = 1'b0;
  logic [31:0] l2_mem  [0:2047];
  logic [31:0] ref_mem [0:2047];
  exp_t        sb [$];
  exp_t        mon_e;
  vec_t        vecs [14];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Scoreboard consumer and L2-request monitor
  always @(negedge clk) begin
    if (rst_n && bus.cpu_ready) begin
      done_cnt++;
      ready_cyc = cyc;
      if (sb.size() == 0) begin
        chk("unexpected_ready", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("cpu_rdata", bus.cpu_rdata, mon_e.rdata);
        chk("cpu_hit", {31'd0, bus.cpu_hit}, {31'd0, mon_e.hit});
      end
    end
    if (bus.l2_read) begin
      l2_rd_cycles++;
      l2_rd_addr = bus.l2_addr;
    end
  end

  // Behavioural L2
  initial begin
    blk_t blk;
    logic [10:0] base;
    bus.l2_ready         = 1'b0;
    bus.l2_block_valid   = 1'b0;
    bus.l2_block_data_in = '0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && !l2_stall && (bus.l2_read || bus.l2_write)) begin
        repeat (c_l2_lat) begin @(posedge clk); #1; end
        if (rst_n && !l2_stall && (bus.l2_read || bus.l2_write)) begin
          base = bus.l2_addr;
          if (bus.l2_write) begin
            blk = bus.l2_data_out;
            last_wr_blk  = blk;
            last_wr_addr = base;
            for (int i = 0; i < 32; i++) l2_mem[int'(base) + i] = blk[i];
            wr_cnt++;
            bus.l2_block_valid = 1'b0;
          end else begin
            for (int i = 0; i < 32; i++) blk[i] = l2_mem[int'(base) + i];
            bus.l2_block_data_in = blk;
            bus.l2_block_valid   = !nack_next;
            nack_next = 1'b0;
          end
          bus.l2_ready = 1'b1;
          @(posedge clk); #1;
          bus.l2_ready       = 1'b0;
          bus.l2_block_valid = 1'b0;
        end
      end
    end
  end

  task automatic issue(input vec_t v);
    int start;
    int to;
    sb.push_back('{v.exp_rdata, v.exp_hit});
    if (v.wr) ref_mem[v.addr] = v.wdata;
    start = done_cnt;
    @(posedge clk); #1;
    bus.cpu_addr  = v.addr;
    bus.cpu_wdata = v.wdata;
    bus.cpu_rd    = v.rd;
    bus.cpu_wr    = v.wr;
    req_cyc       = cyc;
    @(posedge clk); #1;
    bus.cpu_rd = 1'b0;
    bus.cpu_wr = 1'b0;
    to = 0;
    while (done_cnt == start && to < 400) begin
      @(posedge clk); #1;
      to++;
    end
    if (done_cnt == start) begin
      checks++;
      $display("FAIL timeout addr %h: no cpu_ready within %0d cycles", v.addr, to);
      if (sb.size() > 0) void'(sb.pop_back());
    end
  endtask

  task automatic run_vec(input vec_t v);
    int rd0;
    int wr0;
    int bad;
    rd0 = l2_rd_cycles;
    wr0 = wr_cnt;
    issue(v);
    if (v.exp_hit) chk("hit_no_l2_read", l2_rd_cycles - rd0, 0);
    else           chk("miss_l2_addr", {21'd0, l2_rd_addr}, {21'd0, v.addr[10:5], 5'd0});
    if (v.exp_hit && !v.wr) chk("hit_latency", ready_cyc - req_cyc, 1);
    if (v.wr) begin
      chk("wr_sent", wr_cnt - wr0, 1);
      chk("wr_l2_addr", {21'd0, last_wr_addr}, {21'd0, v.addr[10:5], 5'd0});
      bad = 0;
      for (int i = 0; i < 32; i++)
        if (last_wr_blk[i] !== ref_mem[int'(last_wr_addr) + i]) bad++;
      chk("wr_block_words_wrong", bad, 0);
    end
  endtask

  initial begin
    vec_t v;
    for (int a = 0; a < 2048; a++) begin
      l2_mem[a]  = 32'h1000_0000 | a;
      ref_mem[a] = 32'h1000_0000 | a;
    end
    l2_mem[11'h040]  = 32'hA5A5_0000;
    ref_mem[11'h040] = 32'hA5A5_0000;

    //           rd wr addr     wdata         exp_rdata     hit
    vecs[0]  = '{1, 0, 11'h040, 32'h0,        32'hA5A5_0000, 0};
    vecs[1]  = '{1, 0, 11'h041, 32'h0,        32'h1000_0041, 1};
    vecs[2]  = '{0, 1, 11'h041, 32'hDEAD_BEEF, 32'h0,        1};
    vecs[3]  = '{1, 0, 11'h041, 32'h0,        32'hDEAD_BEEF, 1};
    vecs[4]  = '{0, 1, 11'h300, 32'h0000_1234, 32'h0,        0};
    vecs[5]  = '{1, 0, 11'h300, 32'h0,        32'h0000_1234, 1};
    vecs[6]  = '{1, 0, 11'h301, 32'h0,        32'h1000_0301, 1};
    vecs[7]  = '{1, 0, 11'h440, 32'h0,        32'h1000_0440, 0};
    vecs[8]  = '{1, 0, 11'h040, 32'h0,        32'hA5A5_0000, 0};
    vecs[9]  = '{1, 0, 11'h05F, 32'h0,        32'h1000_005F, 1};
    vecs[10] = '{0, 1, 11'h7FF, 32'hCAFE_F00D, 32'h0,        0};
    vecs[11] = '{1, 0, 11'h7E0, 32'h0,        32'h1000_07E0, 1};
    vecs[12] = '{1, 1, 11'h7E1, 32'h5555_AAAA, 32'h0,        1};
    vecs[13] = '{1, 0, 11'h7E1, 32'h0,        32'h5555_AAAA, 1};

    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.cpu_rd    = 1'b0;
    bus.cpu_wr    = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_ctrl", {27'd0, bus.cpu_ready, bus.cpu_hit, bus.cpu_busy, bus.l2_read, bus.l2_write}, 32'd0);
    chk("reset_rdata", bus.cpu_rdata, 32'd0);
    chk("reset_l2_addr", {21'd0, bus.l2_addr}, 32'd0);

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // L2 answers ready without valid data once; the fetch must retry.
    nack_next = 1'b1;
    v = '{1, 0, 11'h500, 32'h0, 32'h1000_0500, 0};
    run_vec(v);

    // Reset in the middle of a fetch.
    l2_stall = 1'b1;
    @(posedge clk); #1;
    bus.cpu_addr = 11'h080;
    bus.cpu_rd   = 1'b1;
    @(posedge clk); #1;
    bus.cpu_rd = 1'b0;
    @(posedge clk); #1;
    chk("fetch_l2_read", {31'd0, bus.l2_read}, 32'd1);
    chk("fetch_l2_addr", {21'd0, bus.l2_addr}, 32'h080);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", {27'd0, bus.cpu_ready, bus.cpu_hit, bus.cpu_busy, bus.l2_read, bus.l2_write}, 32'd0);
    chk("midrst_l2_addr", {21'd0, bus.l2_addr}, 32'd0);
    chk("midrst_l2_data_out", {31'd0, |bus.l2_data_out}, 32'd0);
    chk("midrst_rdata", bus.cpu_rdata, 32'd0);
    @(posedge clk); #1;
    rst_n    = 1'b1;
    l2_stall = 1'b0;
    v = '{1, 0, 11'h040, 32'h0, 32'hA5A5_0000, 0};
    run_vec(v);

    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

endmodule

`default_nettype wire
